// File: rtl/dyn_shiftrow_if.sv
// Stream bundle for the dynamic ShiftRows stage: input side (data + mode) and
// output side (permuted data + selectors), each with its own valid/ready pair.
interface dyn_shiftrow_if #(
    parameter int NCOLS = 4
);
    localparam int W = 32 * NCOLS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   out_sel;

    modport master (
        output in_valid, in_data, in_inv, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, in_data, in_inv, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/dyn_shiftrow_pipe.sv
// Two-stage dynamic ShiftRows (forward/inverse per transaction) with valid/ready
// backpressure; row rotations are picked from permutation-invariant selectors p and q.
module dyn_shiftrow_pipe #(
    parameter int NCOLS = 4
) (
    input logic          clk,
    input logic          rst_n,
    dyn_shiftrow_if.slave bus
);
    localparam int W = 32 * NCOLS;
    localparam int L = 8 * NCOLS;

    logic         s1_valid;
    logic [W-1:0] s1_data;
    logic         s1_inv;
    logic         s1_p;
    logic         s1_q;

    logic         s2_adv;
    logic         s1_adv;

    logic         sel_p;
    logic         sel_q;
    logic [W-1:0] rot_data;

    logic [L-1:0]   row;
    logic [2*L-1:0] dbl;
    logic [3:0]     amt;
    logic [3:0]     sh;

    assign s2_adv       = !bus.out_valid || bus.out_ready;
    assign s1_adv       = s1_valid && s2_adv;
    assign bus.in_ready = !s1_valid || s2_adv;

    // Both selectors only depend on the multiset of bytes within each row,
    // so the inverse pass recovers exactly the selectors used going forward.
    always_comb begin
        sel_p = ^bus.in_data;
        sel_q = 1'b1;
        for (int c = 0; c < NCOLS; c++) begin
            sel_q = sel_q & (^bus.in_data[W-1-8*(4*c+1) -: 8]);
        end
    end

    // Each row is gathered MSB-first and rotated left by sh bytes through a
    // doubled copy; an inverse rotation is a left rotation by NCOLS - a.
    always_comb begin
        rot_data = '0;
        row      = '0;
        dbl      = '0;
        amt      = '0;
        sh       = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < NCOLS; c++) begin
                row[L-1-8*c -: 8] = s1_data[W-1-8*(4*c+r) -: 8];
            end
            if (r == 0) begin
                amt = s1_q ? 4'd1 : 4'd2;
            end else if (r == 1) begin
                amt = 4'd1;
            end else if (r == 2) begin
                amt = s1_p ? 4'd2 : 4'd0;
            end else begin
                amt = s1_p ? 4'd0 : 4'd3;
            end
            sh  = s1_inv ? (4'(NCOLS) - amt) : amt;
            dbl = {row, row} << (8 * sh);
            for (int c = 0; c < NCOLS; c++) begin
                rot_data[W-1-8*(4*c+r) -: 8] = dbl[2*L-1-8*c -: 8];
            end
        end
    end

    // Stage 1 captures the raw state with its mode and selectors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_inv   <= 1'b0;
            s1_p     <= 1'b0;
            s1_q     <= 1'b0;
        end else if (bus.in_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_data <= bus.in_data;
                s1_inv  <= bus.in_inv;
                s1_p    <= sel_p;
                s1_q    <= sel_q;
            end
        end
    end

    // Stage 2 holds the rotated state; it only changes when it may advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sel   <= 2'b00;
        end else if (s2_adv) begin
            bus.out_valid <= s1_adv;
            if (s1_adv) begin
                bus.out_data <= rot_data;
                bus.out_sel  <= {s1_q, s1_p};
            end
        end
    end
endmodule

// File: tb/tb_dyn_shiftrow_pipe.sv
// Scoreboard bench: directed vectors and stalls on NCOLS=4, random mixed-mode
// traffic and forward/inverse round trips on NCOLS=6.
module tb_dyn_shiftrow_pipe;
    localparam logic [127:0] V1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] E1 = 128'h0805020f0c090603000d0a0704010e0b;
    localparam logic [127:0] V3 = 128'h10010000200100003001000040010003;
    localparam logic [127:0] E3 = 128'h20010000300100004001000010010003;

    typedef struct {
        logic [191:0] data;
        logic [1:0]   sel;
        logic [191:0] orig;
        logic         cap;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dyn_shiftrow_if #(.NCOLS(4)) bus4 ();
    dyn_shiftrow_if #(.NCOLS(6)) bus6 ();

    dyn_shiftrow_pipe #(.NCOLS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
    dyn_shiftrow_pipe #(.NCOLS(6)) dut6 (.clk(clk), .rst_n(rst_n), .bus(bus6.slave));

    int tests_run    = 0;
    int tests_failed = 0;

    exp_t         sb4[$];
    exp_t         sb6[$];
    logic [191:0] rt_out[$];
    logic [191:0] rt_orig[$];
    logic         capture_on = 1'b0;
    logic         rand_ready6 = 1'b0;
    logic         stall6 = 1'b0;
    logic [194:0] held6 = '0;

    task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic void ref_model(input logic [191:0] d, input int nc, input logic inv,
                                      output logic [191:0] o, output logic [1:0] sel);
        int   w;
        int   src;
        int   amt[4];
        logic p;
        logic q;
        w = 32 * nc;
        p = ^d;
        q = 1'b1;
        for (int c = 0; c < nc; c++) q = q & (^d[w-1-8*(4*c+1) -: 8]);
        amt[0] = q ? 1 : 2;
        amt[1] = 1;
        amt[2] = p ? 2 : 0;
        amt[3] = p ? 0 : 3;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < nc; c++) begin
                src = inv ? (c - amt[r] + nc) % nc : (c + amt[r]) % nc;
                o[w-1-8*(4*c+r) -: 8] = d[w-1-8*(4*src+r) -: 8];
            end
        end
        sel = {q, p};
    endfunction

    function automatic void pushExpected(input int dut, input logic [191:0] data, input logic inv,
                                         input logic [191:0] exp_data, input logic [1:0] exp_sel);
        exp_t e;
        e.data = exp_data;
        e.sel  = exp_sel;
        e.orig = data;
        e.cap  = (dut == 6) && !inv && capture_on;
        if (dut == 4) sb4.push_back(e);
        else          sb6.push_back(e);
    endfunction

    // Called just after a rising edge; returns just after the edge that accepted the state.
    task automatic applyStimulus(input int dut, input logic [191:0] data, input logic inv,
                                 input logic [191:0] exp_data, input logic [1:0] exp_sel,
                                 output int waits);
        logic accepted;
        logic rdy;
        accepted = 1'b0;
        waits    = 0;
        if (dut == 4) begin
            bus4.in_valid = 1'b1;
            bus4.in_data  = data[127:0];
            bus4.in_inv   = inv;
        end else begin
            bus6.in_valid = 1'b1;
            bus6.in_data  = data;
            bus6.in_inv   = inv;
        end
        while (!accepted && waits < 100) begin
            @(negedge clk);
            rdy = (dut == 4) ? bus4.in_ready : bus6.in_ready;
            if (rdy) begin
                pushExpected(dut, data, inv, exp_data, exp_sel);
                accepted = 1'b1;
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("accept", accepted, 1);
        if (!accepted) begin
            bus4.in_valid = 1'b0;
            bus6.in_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        bus4.in_valid = 1'b0;
        bus6.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string tag, input int dut);
        int n;
        n = 0;
        while (((dut == 4) ? sb4.size() : sb6.size()) != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(tag, (dut == 4) ? sb4.size() : sb6.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus4.out_valid && bus4.out_ready) begin
            if (sb4.size() == 0) begin
                checkOutput("spurious4", bus4.out_valid, 0);
            end else begin
                e = sb4.pop_front();
                checkOutput("data4", bus4.out_data, e.data);
                checkOutput("sel4", bus4.out_sel, e.sel);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stall6 <= 1'b0;
        end else begin
            if (stall6) checkOutput("stall_hold6", {bus6.out_valid, bus6.out_sel, bus6.out_data}, held6);
            stall6 <= bus6.out_valid && !bus6.out_ready;
            held6  <= {1'b1, bus6.out_sel, bus6.out_data};
            if (bus6.out_valid && bus6.out_ready) begin
                if (sb6.size() == 0) begin
                    checkOutput("spurious6", bus6.out_valid, 0);
                end else begin
                    e = sb6.pop_front();
                    checkOutput("data6", bus6.out_data, e.data);
                    checkOutput("sel6", bus6.out_sel, e.sel);
                    if (e.cap && rt_out.size() < 100) begin
                        rt_out.push_back(bus6.out_data);
                        rt_orig.push_back(e.orig);
                    end
                end
            end
        end
    end

    initial begin
        bus6.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus6.out_ready = rand_ready6 ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, tests run %0d", tests_run);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int           waits;
        int           total;
        logic [127:0] held;
        logic [191:0] bp[5];
        logic [191:0] bp_exp[5];
        logic [1:0]   bp_sel[5];
        logic [191:0] d;
        logic [191:0] e;
        logic [1:0]   s;
        logic         inv;
        int           idx;

        rst_n          = 1'b0;
        bus4.in_valid  = 1'b0;
        bus4.in_data   = '0;
        bus4.in_inv    = 1'b0;
        bus4.out_ready = 1'b1;
        bus6.in_valid  = 1'b0;
        bus6.in_data   = '0;
        bus6.in_inv    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", bus4.out_valid, 0);
        checkOutput("rst_out_data", bus4.out_data, 0);
        checkOutput("rst_in_ready", bus4.in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_ready", {bus4.in_ready, bus4.out_valid}, 2'b10);

        applyStimulus(4, {64'h0, V1}, 1'b0, {64'h0, E1}, 2'b00, waits);
        bus4.in_valid = 1'b0;
        checkOutput("lat_early", bus4.out_valid, 0);
        @(posedge clk);
        #1;
        checkOutput("lat_valid", bus4.out_valid, 1);
        checkOutput("fwd_v1", bus4.out_data, E1);
        checkOutput("fwd_v1_sel", bus4.out_sel, 2'b00);
        idle(2);

        total = 0;
        applyStimulus(4, {64'h0, E1}, 1'b1, {64'h0, V1}, 2'b00, waits); total += waits;
        applyStimulus(4, {64'h0, V3}, 1'b0, {64'h0, E3}, 2'b11, waits); total += waits;
        applyStimulus(4, {64'h0, E3}, 1'b1, {64'h0, V3}, 2'b11, waits); total += waits;
        applyStimulus(4, {64'h0, V1}, 1'b0, {64'h0, E1}, 2'b00, waits); total += waits;
        checkOutput("throughput", total, 0);
        idle(4);
        drain("directed_drain", 4);

        for (int k = 0; k < 5; k++) begin
            bp[k] = {64'h0, $urandom(), $urandom(), $urandom(), $urandom()};
            ref_model(bp[k], 4, 1'b0, bp_exp[k], bp_sel[k]);
        end
        bus4.out_ready = 1'b0;
        bus4.in_valid  = 1'b1;
        bus4.in_inv    = 1'b0;
        bus4.in_data   = bp[0][127:0];
        @(negedge clk);
        checkOutput("bp_ready0", bus4.in_ready, 1);
        pushExpected(4, bp[0], 1'b0, bp_exp[0], bp_sel[0]);
        @(posedge clk);
        #1;
        bus4.in_data = bp[1][127:0];
        @(negedge clk);
        checkOutput("bp_ready1", bus4.in_ready, 1);
        pushExpected(4, bp[1], 1'b0, bp_exp[1], bp_sel[1]);
        @(posedge clk);
        #1;
        bus4.in_data = bp[2][127:0];
        held = bus4.out_data;
        checkOutput("bp_out0", bus4.out_data, bp_exp[0]);
        @(negedge clk);
        checkOutput("bp_ready_drop", bus4.in_ready, 0);
        @(posedge clk);
        #1;
        checkOutput("bp_stable", {bus4.out_valid, bus4.out_data}, {1'b1, held});
        bus4.out_ready = 1'b1;
        for (int k = 2; k < 5; k++) applyStimulus(4, bp[k], 1'b0, bp_exp[k], bp_sel[k], waits);
        idle(4);
        drain("bp_drain", 4);

        bus4.out_ready = 1'b0;
        bus4.in_valid  = 1'b1;
        bus4.in_inv    = 1'b0;
        bus4.in_data   = V1;
        @(posedge clk);
        #1;
        bus4.in_data = V3;
        @(posedge clk);
        #1;
        bus4.in_valid = 1'b0;
        checkOutput("rst_pre_full", {bus4.out_valid, bus4.in_ready}, 2'b10);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", bus4.out_valid, 0);
        checkOutput("async_rst_data", {bus4.out_sel, bus4.out_data}, 0);
        checkOutput("async_rst_ready", bus4.in_ready, 1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus4.out_ready = 1'b1;
        checkOutput("rel_ready", bus4.in_ready, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("no_stale", bus4.out_valid, 0);
        end
        @(posedge clk);
        #1;

        rand_ready6 = 1'b1;
        capture_on  = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            if (i % 4 == 0) begin
                for (int c = 0; c < 6; c++) begin
                    idx = 191 - 8 * (4 * c + 1);
                    if (^d[idx -: 8] == 1'b0) d[idx-7] = ~d[idx-7];
                end
            end
            inv = 1'($urandom_range(0, 1));
            ref_model(d, 6, inv, e, s);
            applyStimulus(6, d, inv, e, s, waits);
            if ($urandom_range(0, 7) == 0) begin
                bus6.in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        bus6.in_valid = 1'b0;
        capture_on    = 1'b0;
        drain("rand_drain", 6);

        checkOutput("rt_count", rt_out.size(), 100);
        for (int k = 0; k < rt_out.size(); k++) begin
            ref_model(rt_orig[k], 6, 1'b0, e, s);
            applyStimulus(6, rt_out[k], 1'b1, rt_orig[k], s, waits);
        end
        bus6.in_valid = 1'b0;
        drain("rt_drain", 6);
        rand_ready6 = 1'b0;
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
